// File: rtl/reaction_ctrl.sv
// Reaction-time trial sequencer: random pre-GO wait, counter enable, capture of
// reaction time or timeout, early-press detection and best-time tracking.
module reaction_ctrl #(
    parameter int unsigned TICK_DIV     = 1000,
    parameter int unsigned MIN_DELAY_MS = 1000,
    parameter int unsigned RAND_BITS    = 11,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        response,
    input  logic [13:0] count_time,
    input  logic        count_overflow,
    output logic        count_en,
    output logic        led_go,
    output logic [2:0]  state,
    output logic [13:0] result,
    output logic        result_valid,
    output logic        timeout,
    output logic        foul,
    output logic [13:0] best
);

    localparam int unsigned PW = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 32'd1;
    localparam int unsigned DW = $clog2(MIN_DELAY_MS + (32'd1 << RAND_BITS));
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 32'd1);
    localparam logic [DW-1:0] DELAY_MIN = DW'(MIN_DELAY_MS);
    localparam logic [DW-1:0] DELAY_ONE = DW'(32'd1);
    localparam logic [13:0]   BEST_NONE = 14'h3FFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_MEASURE = 3'd2,
        ST_DONE    = 3'd3,
        ST_FOUL    = 3'd4
    } state_t;

    // Fibonacci step, taps 16,14,13,11: feedback is the parity of the tapped bits
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        lfsr_step = {cur[14:0], ^(cur & 16'hB400)};
    endfunction

    state_t        state_r, state_s;
    logic [15:0]   lfsr_r;
    logic [PW-1:0] presc_r, presc_s;
    logic [DW-1:0] delay_r, delay_s;
    logic [13:0]   result_r, result_s;
    logic [13:0]   best_r, best_s;
    logic          result_valid_r, result_valid_s;
    logic          timeout_r, timeout_s;
    logic          foul_r, foul_s;
    logic          count_en_r, count_en_s;
    logic          led_go_r, led_go_s;

    // Next-state and next-output decode for the trial sequencer
    always_comb begin
        state_s        = state_r;
        presc_s        = presc_r;
        delay_s        = delay_r;
        result_s       = result_r;
        best_s         = best_r;
        result_valid_s = 1'b0;
        timeout_s      = timeout_r;
        foul_s         = foul_r;
        count_en_s     = 1'b0;
        led_go_s       = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE, ST_FOUL: begin
                // A held button blocks the start so a trial never begins pre-fouled
                if (start && !response) begin
                    state_s   = ST_ARM;
                    delay_s   = DELAY_MIN + DW'(lfsr_r[RAND_BITS-1:0]);
                    presc_s   = {PW{1'b0}};
                    timeout_s = 1'b0;
                    foul_s    = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_ARM: begin
                if (response) begin
                    state_s = ST_FOUL;
                    foul_s  = 1'b1;
                end else if (presc_r == PRESC_MAX) begin
                    presc_s = {PW{1'b0}};
                    delay_s = delay_r - DELAY_ONE;
                    if (delay_r == DELAY_ONE) begin
                        state_s    = ST_MEASURE;
                        count_en_s = 1'b1;
                        led_go_s   = 1'b1;
                    end else begin
                        state_s = ST_ARM;
                    end
                end else begin
                    presc_s = presc_r + PW'(32'd1);
                end
            end
            ST_MEASURE: begin
                if (response) begin
                    state_s        = ST_DONE;
                    result_s       = count_time;
                    result_valid_s = 1'b1;
                    if (count_time < best_r) begin
                        best_s = count_time;
                    end else begin
                        best_s = best_r;
                    end
                end else if (count_overflow) begin
                    state_s   = ST_DONE;
                    result_s  = count_time;
                    timeout_s = 1'b1;
                end else begin
                    count_en_s = 1'b1;
                    led_go_s   = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; LFSR free-runs in every state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            lfsr_r         <= LFSR_SEED;
            presc_r        <= {PW{1'b0}};
            delay_r        <= {DW{1'b0}};
            result_r       <= 14'd0;
            best_r         <= BEST_NONE;
            result_valid_r <= 1'b0;
            timeout_r      <= 1'b0;
            foul_r         <= 1'b0;
            count_en_r     <= 1'b0;
            led_go_r       <= 1'b0;
        end else begin
            state_r        <= state_s;
            lfsr_r         <= lfsr_step(lfsr_r);
            presc_r        <= presc_s;
            delay_r        <= delay_s;
            result_r       <= result_s;
            best_r         <= best_s;
            result_valid_r <= result_valid_s;
            timeout_r      <= timeout_s;
            foul_r         <= foul_s;
            count_en_r     <= count_en_s;
            led_go_r       <= led_go_s;
        end
    end

    assign state        = state_r;
    assign count_en     = count_en_r;
    assign led_go       = led_go_r;
    assign result       = result_r;
    assign result_valid = result_valid_r;
    assign timeout      = timeout_r;
    assign foul         = foul_r;
    assign best         = best_r;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Scoreboard bench for reaction_ctrl: stimulus queues expected output tuples,
// a monitor compares them on every state change of the DUT.
module tb_reaction_ctrl;

    localparam int          TICK_DIV     = 10;
    localparam int          MIN_DELAY_MS = 5;
    localparam int          RAND_BITS    = 3;
    localparam int          MAXW         = 20000;
    localparam logic [13:0] OVF_AT       = 14'd9995;
    localparam logic [13:0] NONE         = 14'h3FFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        response = 1'b0;
    logic [13:0] count_time;
    logic        count_overflow;
    logic        count_en, led_go, result_valid, timeout, foul;
    logic [2:0]  state;
    logic [13:0] result, best;

    always #5 clk = ~clk;

    reaction_ctrl #(
        .TICK_DIV(TICK_DIV), .MIN_DELAY_MS(MIN_DELAY_MS),
        .RAND_BITS(RAND_BITS), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .response(response),
        .count_time(count_time), .count_overflow(count_overflow),
        .count_en(count_en), .led_go(led_go), .state(state),
        .result(result), .result_valid(result_valid), .timeout(timeout),
        .foul(foul), .best(best)
    );

    // behavioural ms counter with a one-shot preload for reaching overflow quickly
    logic [13:0] ct_m = 14'd0;
    logic        ov_m = 1'b0;
    int          tk_m = 0;
    logic        preload_req = 1'b0;
    logic [13:0] preload_val = 14'd0;
    assign count_time     = ct_m;
    assign count_overflow = ov_m;

    always @(posedge clk) begin
        if (!count_en) begin
            ct_m <= 14'd0; tk_m <= 0; ov_m <= 1'b0;
        end else if (preload_req) begin
            ct_m <= preload_val; tk_m <= 0;
        end else if (!ov_m) begin
            if (tk_m == TICK_DIV - 1) begin
                tk_m <= 0;
                ct_m <= ct_m + 14'd1;
                if (ct_m + 14'd1 >= OVF_AT) ov_m <= 1'b1;
            end else begin
                tk_m <= tk_m + 1;
            end
        end
    end

    // reference LFSR, x^16+x^14+x^13+x^11
    logic [15:0] m_lfsr;
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  st;
        logic        cen;
        logic        go;
        logic [13:0] res;
        logic        rv;
        logic        to;
        logic        fl;
        logic [13:0] bst;
        int          dly;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [13:0] exp_result = 14'd0;
    logic [13:0] exp_best   = NONE;

    task automatic push_exp(input logic [2:0] st, input logic cen, input logic go,
                            input logic rv, input logic to, input logic fl, input int dly);
        exp_t e;
        e.st = st; e.cen = cen; e.go = go; e.res = exp_result; e.rv = rv;
        e.to = to; e.fl = fl; e.bst = exp_best; e.dly = dly;
        exp_q.push_back(e);
    endtask

    task automatic expired(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: still waiting after %0d cycles, required event never seen", nm, MAXW);
    endtask

    task automatic wait_state(input logic [2:0] s);
        int n = 0;
        while (state != s && n < MAXW) begin @(negedge clk); n++; end
        if (state != s) expired("wait_state");
    endtask

    task automatic wait_time(input logic [13:0] t);
        int n = 0;
        while (count_time != t && n < MAXW) begin @(negedge clk); n++; end
        if (count_time != t) expired("wait_count_time");
    endtask

    task automatic wait_ovf();
        int n = 0;
        while (!count_overflow && n < MAXW) begin @(negedge clk); n++; end
        if (!count_overflow) expired("wait_overflow");
    endtask

    task automatic wait_lfsr(input logic [2:0] v);
        int n = 0;
        while (m_lfsr[2:0] != v && n < MAXW) begin @(negedge clk); n++; end
        if (m_lfsr[2:0] != v) expired("wait_lfsr");
    endtask

    // start pulse; queues ARM and (optionally) MEASURE with the expected wait length
    task automatic do_start(input int want, input bit meas);
        int d;
        if (want >= 0) wait_lfsr(want[2:0]);
        start = 1'b1;
        d = MIN_DELAY_MS + int'(m_lfsr[2:0]);
        push_exp(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        if (meas) push_exp(3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, d * TICK_DIV);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic respond(input logic [13:0] t);
        wait_time(t);
        response = 1'b1;
        exp_result = t;
        if (t < exp_best) exp_best = t;
        push_exp(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        @(negedge clk);
        response = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic preload_9990();
        preload_val = 14'd9990;
        preload_req = 1'b1;
        @(negedge clk);
        preload_req = 1'b0;
    endtask

    initial begin
        fork
            begin : monitor
                exp_t       e;
                logic [2:0] prev_state = 3'd7;
                logic       prev_rv = 1'b0;
                int         last_cyc = 0;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        prev_rv = 1'b0;
                    end else begin
                        if (prev_rv) begin
                            checks++;
                            if (result_valid !== 1'b0) begin
                                errors++;
                                $display("FAIL rv_width: result_valid=%0b one cycle after pulse, required 0", result_valid);
                            end
                        end
                        if (state != prev_state) begin
                            checks++;
                            if (exp_q.size() == 0) begin
                                errors++;
                                $display("FAIL unexpected_event: state %0d->%0d with nothing expected", prev_state, state);
                            end else begin
                                e = exp_q.pop_front();
                                if (state !== e.st || count_en !== e.cen || led_go !== e.go ||
                                    result !== e.res || result_valid !== e.rv || timeout !== e.to ||
                                    foul !== e.fl || best !== e.bst) begin
                                    errors++;
                                    $display("FAIL event: got st=%0d cen=%0b go=%0b res=%0d rv=%0b to=%0b fl=%0b best=%0d, expected st=%0d cen=%0b go=%0b res=%0d rv=%0b to=%0b fl=%0b best=%0d",
                                             state, count_en, led_go, result, result_valid, timeout, foul, best,
                                             e.st, e.cen, e.go, e.res, e.rv, e.to, e.fl, e.bst);
                                end
                                if (e.dly != 0) begin
                                    checks++;
                                    if (cyc - last_cyc != e.dly) begin
                                        errors++;
                                        $display("FAIL go_delay: GO after %0d clocks, expected %0d", cyc - last_cyc, e.dly);
                                    end
                                end
                            end
                            last_cyc   = cyc;
                            prev_state = state;
                        end else if (result_valid) begin
                            checks++;
                            errors++;
                            $display("FAIL spurious_rv: result_valid=1 in state %0d without a capture, expected 0", state);
                        end
                        prev_rv = result_valid;
                    end
                end
            end
        join_none

        // reset
        push_exp(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // first trial with lfsr[2:0]=3 -> 8 ms wait, then best sequence 123,200,50,50
        do_start(3, 1'b1);
        respond(14'd123);
        do_start(-1, 1'b1);
        respond(14'd200);
        do_start(-1, 1'b1);
        respond(14'd50);
        do_start(-1, 1'b1);
        respond(14'd50);

        // early press, start blocked while held, then a clean trial
        do_start(-1, 1'b0);
        repeat (19) @(negedge clk);
        response = 1'b1;
        push_exp(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        response = 1'b0;
        repeat (2) @(negedge clk);
        do_start(-1, 1'b1);
        respond(14'd60);

        // counter overflow without response
        do_start(-1, 1'b1);
        wait_state(3'd2);
        exp_result = OVF_AT;
        push_exp(3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        preload_9990();
        wait_state(3'd3);
        repeat (3) @(negedge clk);

        // response and overflow together: capture wins
        do_start(-1, 1'b1);
        wait_state(3'd2);
        preload_9990();
        wait_ovf();
        response = 1'b1;
        exp_result = OVF_AT;
        push_exp(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        @(negedge clk);
        response = 1'b0;
        repeat (3) @(negedge clk);

        // start ignored in MEASURE, then asynchronous reset mid-MEASURE
        do_start(-1, 1'b1);
        wait_state(3'd2);
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        exp_result = 14'd0;
        exp_best   = NONE;
        push_exp(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if (count_en !== 1'b0 || led_go !== 1'b0 || state !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: got count_en=%0b led_go=%0b state=%0d, expected 0 0 0", count_en, led_go, state);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d expected events never seen, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
